// File: rtl/match_bind_pkg.sv
// Shared types and constants for the match/bind classifier slice.
package match_bind_pkg;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_MSB  = 2'd0,
    MODE_LSB  = 2'd1,
    MODE_PAR  = 2'd2,
    MODE_PASS = 2'd3
  } mode_t;

  localparam logic [1:0] TAG_INIT = 2'b10;

endpackage

// File: rtl/match_bind_pred.sv
// Combinational predicate: selects MSB, LSB or parity of the word; pass mode disables counting.
module match_bind_pred
  import match_bind_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_data,
  input  mode_t            i_mode,
  output logic             o_pred,
  output logic             o_count_en
);

  always_comb begin
    o_pred     = 1'b0;
    o_count_en = 1'b1;
    unique case (i_mode)
      MODE_MSB:  o_pred = i_data[WIDTH-1];
      MODE_LSB:  o_pred = i_data[0];
      MODE_PAR:  o_pred = ^i_data;
      MODE_PASS: o_count_en = 1'b0;
    endcase
  end

endmodule

// File: rtl/match_bind_classifier.sv
// Streaming match/bind classifier: one-entry registered output stage with pass-through
// ready, a one-cycle init beat after reset, and saturating match/miss counters.
module match_bind_classifier
  import match_bind_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CNT_W    = 16,
  parameter logic [1:0]  INIT_TAG = TAG_INIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_tag,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_load_init;
  logic             w_accept;
  logic             w_pred;
  logic             w_count_en;
  logic [1:0]       w_tag;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [1:0]       r_out_tag;
  logic [CNT_W-1:0] r_match_cnt;
  logic [CNT_W-1:0] r_miss_cnt;

  match_bind_pred #(
    .WIDTH (WIDTH)
  ) u_pred (
    .i_data     (in_data),
    .i_mode     (mode_t'(mode)),
    .o_pred     (w_pred),
    .o_count_en (w_count_en)
  );

  assign w_accept = in_valid & in_ready;
  assign w_tag    = w_count_en ? {1'b0, w_pred} : 2'b00;

  // in_ready deliberately ignores in_valid.
  always_comb begin
    w_state_nxt = r_state;
    w_load_init = 1'b0;
    in_ready    = 1'b0;
    case (r_state)
      INIT: begin
        w_load_init = 1'b1;
        w_state_nxt = HOLD;
      end
      RUN: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = HOLD;
      end
      HOLD: begin
        in_ready = out_ready;
        if (out_ready && !in_valid) w_state_nxt = RUN;
      end
      default: w_state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= INIT;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_tag   <= 2'b00;
    end else if (w_load_init) begin
      r_out_valid <= 1'b1;
      r_out_data  <= '0;
      r_out_tag   <= INIT_TAG;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= in_data;
      r_out_tag   <= w_tag;
    end else if (r_state == HOLD && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Clear has priority over a same-cycle increment; both counters saturate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
    end else if (cnt_clr) begin
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
    end else if (w_accept && w_count_en) begin
      if (w_pred && (r_match_cnt != '1)) r_match_cnt <= r_match_cnt + 1'b1;
      if (!w_pred && (r_miss_cnt != '1)) r_miss_cnt <= r_miss_cnt + 1'b1;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_tag   = r_out_tag;
  assign match_cnt = r_match_cnt;
  assign miss_cnt  = r_miss_cnt;

endmodule

// File: tb/tb_match_bind_classifier.sv
// Scoreboard bench: a default-width instance plus a CNT_W=2 instance share all stimulus.
module tb_match_bind_classifier;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic [1:0]   mode;
  logic         out_ready;
  logic         cnt_clr;

  logic         in_ready,  s_in_ready;
  logic         out_valid, s_out_valid;
  logic [W-1:0] out_data,  s_out_data;
  logic [1:0]   out_tag,   s_out_tag;
  logic [15:0]  match_cnt, miss_cnt;
  logic [1:0]   s_match,   s_miss;

  always #5 clk = ~clk;

  match_bind_classifier u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .cnt_clr   (cnt_clr),
    .match_cnt (match_cnt),
    .miss_cnt  (miss_cnt)
  );

  match_bind_classifier #(
    .CNT_W (2)
  ) u_dut_sat (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (s_in_ready),
    .in_data   (in_data),
    .mode      (mode),
    .out_valid (s_out_valid),
    .out_ready (out_ready),
    .out_data  (s_out_data),
    .out_tag   (s_out_tag),
    .cnt_clr   (cnt_clr),
    .match_cnt (s_match),
    .miss_cnt  (s_miss)
  );

  int           n_cmp = 0;
  int           n_err = 0;
  logic [W+1:0] sb_q[$];
  bit           m_init, m_full;
  int           m_match, m_miss;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic exp_ready();
    return !m_init && (!m_full || out_ready);
  endfunction

  function automatic logic [1:0] exp_tag(input logic [W-1:0] d, input logic [1:0] m);
    case (m)
      2'd0:    return {1'b0, d[W-1]};
      2'd1:    return {1'b0, d[0]};
      2'd2:    return {1'b0, ^d};
      default: return 2'b00;
    endcase
  endfunction

  function automatic int clamp(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_reset();
    m_init  = 1'b1;
    m_full  = 1'b0;
    m_match = 0;
    m_miss  = 0;
    sb_q.delete();
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic cycle();
    logic         acc, cons;
    logic [W+1:0] e;
    logic [W+1:0] nw;
    #1;
    check_eq("in_ready", in_ready, exp_ready());
    check_eq("sat_in_ready", s_in_ready, exp_ready());
    check_eq("out_valid", out_valid, m_full);
    check_eq("sat_out_valid", s_out_valid, m_full);
    cons = m_full && out_ready;
    acc  = in_valid && exp_ready();
    nw   = {in_data, exp_tag(in_data, mode)};
    if (cons) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_underflow", sb_q.size(), 1);
      end else begin
        e = sb_q.pop_front();
        check_eq("out_data", out_data, e[W+1:2]);
        check_eq("out_tag", out_tag, e[1:0]);
        check_eq("sat_out_data", s_out_data, e[W+1:2]);
      end
    end
    @(posedge clk);
    if (cnt_clr) begin
      m_match = 0;
      m_miss  = 0;
    end else if (acc && !m_init && mode != 2'd3) begin
      if (nw[0]) m_match++;
      else       m_miss++;
    end
    if (m_init) begin
      m_init = 1'b0;
      m_full = 1'b1;
      sb_q.push_back({{W{1'b0}}, 2'b10});
    end else begin
      if (acc) sb_q.push_back(nw);
      m_full = acc || (m_full && !out_ready);
    end
    #1;
    check_eq("match_cnt", match_cnt, clamp(m_match, 65535));
    check_eq("miss_cnt", miss_cnt, clamp(m_miss, 65535));
    check_eq("sat_match", s_match, clamp(m_match, 3));
    check_eq("sat_miss", s_miss, clamp(m_miss, 3));
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic [1:0] m);
    in_valid = v;
    in_data  = d;
    mode     = m;
  endtask

  initial begin
    logic [W-1:0] odd_words [6];
    odd_words = '{8'h01, 8'h03, 8'h05, 8'h07, 8'h09, 8'h0B};
    rst = 1'b1;
    drive(1'b0, '0, 2'd0);
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_tag", out_tag, 0);
    check_eq("rst_match", match_cnt, 0);
    check_eq("rst_miss", miss_cnt, 0);
    rst = 1'b0;

    // INIT cycle, then the init beat.
    cycle();
    check_eq("init_tag", out_tag, 2'b10);
    check_eq("init_data", out_data, 0);
    cycle();

    // MSB mode, back-to-back stream.
    drive(1'b1, 8'h80, 2'd0); cycle();
    drive(1'b1, 8'h7F, 2'd0); cycle();
    drive(1'b1, 8'hFF, 2'd0); cycle();
    drive(1'b0, 8'h00, 2'd0); cycle();
    cycle();
    check_eq("msb_match", match_cnt, 2);
    check_eq("msb_miss", miss_cnt, 1);

    // Parity word held under backpressure; mode/data wiggle must not disturb it.
    out_ready = 1'b0;
    drive(1'b1, 8'h07, 2'd2); cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h11 + 8'(i), 2'(i));
      check_eq("stall_valid", out_valid, 1);
      check_eq("stall_data", out_data, 8'h07);
      check_eq("stall_tag", out_tag, 2'b01);
      check_eq("stall_ready", in_ready, 0);
      cycle();
    end
    out_ready = 1'b1;
    drive(1'b0, 8'h00, 2'd0); cycle();
    cycle();

    // Saturation on the CNT_W=2 instance, then clear racing an accept.
    cnt_clr = 1'b1; cycle();
    cnt_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, odd_words[i], 2'd1);
      cycle();
    end
    check_eq("sat_hold3", s_match, 3);
    drive(1'b1, odd_words[5], 2'd1);
    cnt_clr = 1'b1; cycle();
    cnt_clr = 1'b0;
    check_eq("clr_match", match_cnt, 0);
    check_eq("clr_sat_match", s_match, 0);

    // Pass mode: tag 00, no counting.
    drive(1'b1, 8'h55, 2'd3); cycle();
    drive(1'b1, 8'hAA, 2'd3); cycle();
    drive(1'b0, 8'h00, 2'd0); cycle();
    check_eq("pass_match", match_cnt, 0);

    // Reset while 0x3C is held.
    out_ready = 1'b0;
    drive(1'b1, 8'h3C, 2'd0); cycle();
    drive(1'b0, 8'h00, 2'd0);
    #2 rst = 1'b1;
    #1;
    check_eq("midrst_valid", out_valid, 0);
    check_eq("midrst_ready", in_ready, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    cycle();
    check_eq("reinit_tag", out_tag, 2'b10);
    cycle();
    cycle();
    check_eq("sb_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
